// File: rtl/thread_group_scheduler_pkg.sv
// Shared constants, FSM state type and helpers for the thread-group scheduler.
package thread_group_scheduler_pkg;

    // Thread-width modes as presented on cmd_mode.
    localparam logic [1:0] MODE_FULL    = 2'b00;
    localparam logic [1:0] MODE_HALF    = 2'b01;
    localparam logic [1:0] MODE_QUARTER = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    // Thread-mask decoder codes understood by the compute unit.
    localparam logic [3:0] TM_ALL     = 4'b0000;
    localparam logic [3:0] TM_HALF_LO = 4'b1000;
    localparam logic [3:0] TM_HALF_HI = 4'b1010;
    localparam logic [3:0] TM_Q0      = 4'b1100;
    localparam logic [3:0] TM_Q1      = 4'b1101;
    localparam logic [3:0] TM_Q2      = 4'b1110;
    localparam logic [3:0] TM_Q3      = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Non-empty flag per thread group; the reserved mode behaves as 8-wide.
    function automatic logic [3:0] build_pend(input logic [1:0] mode, input logic [7:0] mask);
        logic [3:0] pend;
        case (mode)
            MODE_HALF:    pend = {2'b00, |mask[7:4], |mask[3:0]};
            MODE_QUARTER: pend = {|mask[7:6], |mask[5:4], |mask[3:2], |mask[1:0]};
            default:      pend = {3'b000, |mask};
        endcase
        return pend;
    endfunction

    // Decoder code for group idx under the given mode.
    function automatic logic [3:0] tm_code(input logic [1:0] mode, input logic [1:0] idx);
        logic [3:0] code;
        case (mode)
            MODE_HALF:    code = idx[0] ? TM_HALF_HI : TM_HALF_LO;
            MODE_QUARTER: begin
                case (idx)
                    2'd0:    code = TM_Q0;
                    2'd1:    code = TM_Q1;
                    2'd2:    code = TM_Q2;
                    default: code = TM_Q3;
                endcase
            end
            default:      code = TM_ALL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/thread_group_scheduler_if.sv
// Command, issue and completion signals between front end, scheduler and datapath.
interface thread_group_scheduler_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [7:0]       cmd_exec_mask;
    logic [TAG_W-1:0] cmd_tag;
    logic             issue_valid;
    logic             issue_ready;
    logic [3:0]       issue_threads_mask;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_last;
    logic             done_valid;
    logic [TAG_W-1:0] done_tag;
    logic             busy;

    // Environment side: front end plus datapath.
    modport master (
        output cmd_valid, cmd_mode, cmd_exec_mask, cmd_tag, issue_ready,
        input  cmd_ready, issue_valid, issue_threads_mask, issue_tag, issue_last,
        input  done_valid, done_tag, busy
    );

    // Scheduler side.
    modport slave (
        input  cmd_valid, cmd_mode, cmd_exec_mask, cmd_tag, issue_ready,
        output cmd_ready, issue_valid, issue_threads_mask, issue_tag, issue_last,
        output done_valid, done_tag, busy
    );
endinterface

// File: rtl/thread_group_scheduler_group_pick.sv
// Lowest-set-bit priority encoder over the pending thread groups.
module group_pick (
    input  logic [3:0] req_i,
    output logic [1:0] idx_o,
    output logic [3:0] onehot_o,
    output logic       is_last_o
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx_o     = 2'd0;
        onehot_o  = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o    = 2'(i);
                onehot_o = 4'b0001 << i;
            end
        end
        is_last_o = (req_i != 4'b0000) && ((req_i & (req_i - 4'd1)) == 4'b0000);
    end

endmodule

// File: rtl/thread_group_scheduler.sv
// Splits one compute-unit command into 1, 2 or 4 issue passes, skipping empty groups.
module thread_group_scheduler
    import thread_group_scheduler_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    thread_group_scheduler_if.slave  bus
);

    state_e           state_q;
    logic [3:0]       pend_q;
    logic [1:0]       mode_q;
    logic [TAG_W-1:0] tag_q;
    logic             ready_q;

    logic [3:0]       cmd_pend;
    logic [1:0]       pick_idx;
    logic [3:0]       pick_onehot;
    logic             pick_last;
    logic             in_issue;

    assign cmd_pend = build_pend(bus.cmd_mode, bus.cmd_exec_mask);
    assign in_issue = (state_q == ST_ISSUE);

    group_pick u_pick (
        .req_i     (pend_q),
        .idx_o     (pick_idx),
        .onehot_o  (pick_onehot),
        .is_last_o (pick_last)
    );

    // Command FSM: accept, walk the pending groups one handshake at a time, then a single DONE cycle.
    // ready_q is a register so cmd_ready stays low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 4'b0000;
            mode_q  <= MODE_FULL;
            tag_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        tag_q   <= bus.cmd_tag;
                        mode_q  <= (bus.cmd_mode == MODE_RSVD) ? MODE_FULL : bus.cmd_mode;
                        pend_q  <= cmd_pend;
                        state_q <= (cmd_pend != 4'b0000) ? ST_ISSUE : ST_DONE;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.issue_ready) begin
                        pend_q <= pend_q & ~pick_onehot;
                        if (pick_last) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    pend_q  <= 4'b0000;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    assign bus.cmd_ready          = ready_q;
    assign bus.issue_valid        = in_issue;
    assign bus.issue_threads_mask = in_issue ? tm_code(mode_q, pick_idx) : TM_ALL;
    assign bus.issue_tag          = tag_q;
    assign bus.issue_last         = in_issue & pick_last;
    assign bus.done_valid         = (state_q == ST_DONE);
    assign bus.done_tag           = tag_q;
    assign bus.busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_thread_group_scheduler.sv
// Randomized self-checking bench for thread_group_scheduler against a pass-list reference model.
module tb_thread_group_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    thread_group_scheduler_if #(.TAG_W(4)) bus ();

    thread_group_scheduler #(.TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected decoder codes still to be issued for the current command.
    logic [3:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: split the 8 threads into groups of the mode's width and list a code for each non-empty group.
    task automatic build_model(input logic [1:0] mode, input logic [7:0] mask);
        int width;
        exp_q.delete();
        width = (mode == 2'd1) ? 4 : (mode == 2'd2) ? 2 : 8;
        for (int g = 0; g < 8 / width; g++) begin
            logic [7:0] grp;
            logic [3:0] code;
            grp = (mask >> (g * width)) & 8'((1 << width) - 1);
            if (grp != 8'h00) begin
                if (width == 8)      code = 4'b0000;
                else if (width == 4) code = (g == 0) ? 4'b1000 : 4'b1010;
                else                 code = 4'(12 + g);
                exp_q.push_back(code);
            end
        end
    endtask

    // Offer one command, follow it to completion and check every cycle; called and returns on a negedge.
    task automatic run_cmd(input logic [1:0] mode, input logic [7:0] mask, input logic [3:0] tag,
                           input bit rnd_ready, input bit hold);
        int  waits;
        int  cyc;
        int  passes;
        bit  seen_done;
        waits     = 0;
        seen_done = 1'b0;
        build_model(mode, mask);
        passes = exp_q.size();
        bus.cmd_mode      = mode;
        bus.cmd_exec_mask = mask;
        bus.cmd_tag       = tag;
        bus.cmd_valid     = 1'b1;
        while (bus.cmd_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            chk("accept_timeout", 32'(0), 32'(1));
            bus.cmd_valid = 1'b0;
            return;
        end
        bus.issue_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cyc = 1;
        while (!seen_done && cyc <= 40) begin
            chk("cmd_ready_low", 32'(bus.cmd_ready), 32'(0));
            chk("busy_high", 32'(bus.busy), 32'(1));
            if (exp_q.size() > 0) begin
                chk("issue_valid", 32'(bus.issue_valid), 32'(1));
                chk("done_early", 32'(bus.done_valid), 32'(0));
                chk("tmask", 32'(bus.issue_threads_mask), 32'(exp_q[0]));
                chk("issue_tag", 32'(bus.issue_tag), 32'(tag));
                chk("issue_last", 32'(bus.issue_last), 32'(exp_q.size() == 1));
                bus.issue_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.issue_ready) void'(exp_q.pop_front());
            end else begin
                chk("issue_valid_low", 32'(bus.issue_valid), 32'(0));
                chk("done_valid", 32'(bus.done_valid), 32'(1));
                chk("done_tag", 32'(bus.done_tag), 32'(tag));
                if (!rnd_ready) chk("done_cycle", 32'(cyc), 32'(passes + 1));
                seen_done = 1'b1;
                bus.issue_ready = 1'($urandom_range(0, 1));
                if (hold) bus.cmd_valid = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen_done) begin
            chk("done_timeout", 32'(0), 32'(1));
        end else begin
            chk("ready_back", 32'(bus.cmd_ready), 32'(1));
            chk("done_clear", 32'(bus.done_valid), 32'(0));
            chk("idle_no_issue", 32'(bus.issue_valid), 32'(0));
            chk("idle_busy", 32'(bus.busy), 32'(0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(0));
        chk({tag, "_issue_valid"}, 32'(bus.issue_valid), 32'(0));
        chk({tag, "_issue_last"}, 32'(bus.issue_last), 32'(0));
        chk({tag, "_tmask"}, 32'(bus.issue_threads_mask), 32'(0));
        chk({tag, "_issue_tag"}, 32'(bus.issue_tag), 32'(0));
        chk({tag, "_done_valid"}, 32'(bus.done_valid), 32'(0));
        chk({tag, "_done_tag"}, 32'(bus.done_tag), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    endtask

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_mode      = 2'b00;
        bus.cmd_exec_mask = 8'h00;
        bus.cmd_tag       = 4'h0;
        bus.issue_ready   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'(1));
        chk("post_rst_busy", 32'(bus.busy), 32'(0));

        // Directed cases.
        run_cmd(2'b00, 8'hFF, 4'd1, 1'b0, 1'b0);
        run_cmd(2'b01, 8'hF0, 4'd5, 1'b0, 1'b0);
        run_cmd(2'b10, 8'b1000_0101, 4'd6, 1'b1, 1'b0);
        run_cmd(2'b00, 8'h00, 4'd2, 1'b0, 1'b0);
        run_cmd(2'b01, 8'h00, 4'd3, 1'b0, 1'b0);
        run_cmd(2'b10, 8'h00, 4'd4, 1'b0, 1'b0);
        run_cmd(2'b11, 8'h01, 4'd9, 1'b0, 1'b0);
        run_cmd(2'b11, 8'h80, 4'd10, 1'b1, 1'b0);
        run_cmd(2'b10, 8'hFF, 4'd11, 1'b0, 1'b0);

        // Back-to-back with cmd_valid held high through the DONE cycle.
        run_cmd(2'b01, 8'hFF, 4'd7, 1'b0, 1'b1);
        run_cmd(2'b10, 8'h3C, 4'd8, 1'b0, 1'b1);
        run_cmd(2'b00, 8'h10, 4'd12, 1'b0, 1'b0);

        // Randomized commands.
        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset during pass 2 of a 4-pass command.
        bus.cmd_mode      = 2'b10;
        bus.cmd_exec_mask = 8'hFF;
        bus.cmd_tag       = 4'd13;
        bus.cmd_valid     = 1'b1;
        bus.issue_ready   = 1'b1;
        chk("abort_ready", 32'(bus.cmd_ready), 32'(1));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("abort_pass1", 32'(bus.issue_threads_mask), 32'(4'b1100));
        @(negedge clk);
        chk("abort_pass2", 32'(bus.issue_threads_mask), 32'(4'b1101));
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done_valid), 32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_back", 32'(bus.cmd_ready), 32'(1));
        run_cmd(2'b10, 8'hFF, 4'd14, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
